peripheral_mpi_noc_packet_buffer: RTL

Store-and-forward packet buffer between the MPI peripheral's NoC output (`noc_out_*`) and the router's local input port. Flits from the MPI endpoint are accepted as they arrive. A packet is offered downstream only after its last flit is stored, so the router link is never stalled by a slow bus-side writer. Packets longer than the buffer fall back to cut-through so the link cannot deadlock.

---
 rtl/peripheral_mpi_pkg.sv | 23 ++
 rtl/peripheral_mpi_noc_packet_buffer_if.sv | 14 +
 rtl/peripheral_mpi_fifo_ram.sv | 29 ++
 rtl/peripheral_mpi_noc_packet_buffer.sv | 114 +++++++++++
 4 files changed

// File: rtl/peripheral_mpi_pkg.sv
// Shared definitions for the MPI peripheral NoC path: flit entry layout and
// pointer sizing for the store-and-forward packet buffer.
package peripheral_mpi_pkg;

   localparam int NOC_FLIT_WIDTH_DEF = 32;
   localparam int DEPTH_DEF          = 16;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int PTR_W_DEF = ptr_width(DEPTH_DEF);

   // One stored entry: end-of-packet marker above the flit payload.
   typedef struct packed {
      logic                          last;
      logic [NOC_FLIT_WIDTH_DEF-1:0] flit;
   } flit_entry_t;

   localparam int ENTRY_W_DEF = $bits(flit_entry_t);

endpackage

// File: rtl/peripheral_mpi_noc_packet_buffer_if.sv
// One NoC flit channel. The master drives flit/last/valid, the slave drives
// ready. Handshake: a flit transfers on a rising edge where valid && ready;
// once valid is high, flit and last stay stable until that transfer.
interface peripheral_mpi_noc_packet_buffer_if #(
   parameter int NOC_FLIT_WIDTH = 32
);
   logic [NOC_FLIT_WIDTH-1:0] flit;
   logic                      last;
   logic                      valid;
   logic                      ready;

   modport master (output flit, output last, output valid, input  ready);
   modport slave  (input  flit, input  last, input  valid, output ready);
endinterface

// File: rtl/peripheral_mpi_fifo_ram.sv
// Register-array storage for the packet buffer: one synchronous write port,
// one asynchronous read port. Contents are deliberately not reset.
module peripheral_mpi_fifo_ram
   import peripheral_mpi_pkg::*;
#(
   parameter  int DATA_W = 33,
   parameter  int DEPTH  = 16,
   localparam int AW     = ptr_width(DEPTH) - 1
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Store the incoming entry at the write address.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/peripheral_mpi_noc_packet_buffer.sv
// Store-and-forward packet buffer between the MPI endpoint and the router's
// local input. A packet is offered only once its last flit is stored; a
// packet that fills the buffer without ending switches to cut-through so
// the link cannot deadlock.
module peripheral_mpi_noc_packet_buffer
   import peripheral_mpi_pkg::*;
#(
   parameter int NOC_FLIT_WIDTH = 32,
   parameter int DEPTH          = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   peripheral_mpi_noc_packet_buffer_if.slave  noc_in,
   peripheral_mpi_noc_packet_buffer_if.master noc_out,
   output logic [$clog2(DEPTH+1)-1:0]   pkt_count,
   output logic                         oversize
);

   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = NOC_FLIT_WIDTH + 1;

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_pkt_count;
   logic          r_cut_through;

   logic          w_empty;
   logic          w_full;
   logic          w_wr;
   logic          w_rd;
   logic          w_pkt_in;
   logic          w_pkt_out;
   logic          w_start_cut;
   logic          w_out_valid;
   logic [EW-1:0] w_wr_entry;
   logic [EW-1:0] w_rd_entry;

   // Occupancy flags, handshakes and the packet-boundary events.
   always_comb begin
      w_empty     = (r_wr_ptr == r_rd_ptr);
      w_full      = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
      // A full buffer holding no complete packet can only drain by
      // forwarding the partial packet it holds.
      w_start_cut = w_full && (r_pkt_count == '0) && !r_cut_through;
      w_out_valid = !w_empty && ((r_pkt_count != '0) || w_full || r_cut_through);
      w_wr        = noc_in.valid && !w_full;
      w_rd        = w_out_valid && noc_out.ready;
      w_pkt_in    = w_wr && noc_in.last;
      w_pkt_out   = w_rd && w_rd_entry[NOC_FLIT_WIDTH];
      w_wr_entry  = {noc_in.last, noc_in.flit};
   end

   peripheral_mpi_fifo_ram #(
      .DATA_W (EW),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_wr),
      .i_waddr (r_wr_ptr[AW-1:0]),
      .i_wdata (w_wr_entry),
      .i_raddr (r_rd_ptr[AW-1:0]),
      .o_rdata (w_rd_entry)
   );

   // Advance pointers on each accepted write and each completed read.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
      end
   end

   // Count complete packets held; a simultaneous in and out cancel.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pkt_count <= '0;
      end else begin
         case ({w_pkt_in, w_pkt_out})
            2'b10:   r_pkt_count <= r_pkt_count + CW'(1);
            2'b01:   r_pkt_count <= r_pkt_count - CW'(1);
            default: r_pkt_count <= r_pkt_count;
         endcase
      end
   end

   // Cut-through mode lasts until the oversized packet's last flit leaves.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cut_through <= 1'b0;
      end else if (w_start_cut) begin
         r_cut_through <= 1'b1;
      end else if (w_pkt_out) begin
         r_cut_through <= 1'b0;
      end
   end

   assign noc_in.ready  = !w_full;
   assign noc_out.valid = w_out_valid;
   assign noc_out.flit  = w_rd_entry[NOC_FLIT_WIDTH-1:0];
   assign noc_out.last  = w_rd_entry[NOC_FLIT_WIDTH];
   assign pkt_count     = r_pkt_count;
   assign oversize      = w_start_cut;

endmodule
